// File: rtl/global_defs.sv
// rtl/global_defs.sv - shared MPU element width, index width and size-limit constants
package global_defs;
  localparam int FPBITS          = 31;
  localparam int MBITS           = 2;
  localparam int NBITS           = 2;
  localparam int M               = 4;
  localparam int N               = 4;
  localparam int MATRIX_REG_BITS = 2;
endpackage

// File: rtl/mpu_pkg.sv
// rtl/mpu_pkg.sv - store-path state encoding, buffer entry type and size check
package mpu_pkg;
  import global_defs::*;

  typedef enum logic [1:0] {
    STORE_IDLE  = 2'd0,
    STORE_READ  = 2'd1,
    STORE_DRAIN = 2'd2,
    STORE_DONE  = 2'd3
  } store_state_t;

  localparam int STORE_BUF_DEPTH = 2;

  typedef struct packed {
    logic [FPBITS:0] element;
    logic [MBITS:0]  i;
    logic [NBITS:0]  j;
  } store_entry_t;

  // Empty matrices are rejected along with oversized ones.
  function automatic logic size_error(input logic [MBITS:0] m, input logic [NBITS:0] n);
    return (int'(m) > M) || (int'(n) > N) || (m == '0) || (n == '0);
  endfunction
endpackage

// File: rtl/mpu_store_if.sv
// rtl/mpu_store_if.sv - store-path element stream toward external memory
interface mpu_store_if;
  import global_defs::*;

  logic            mem_store_valid_out;
  logic            mem_store_ready_in;
  logic [FPBITS:0] mem_store_element_out;
  logic [MBITS:0]  mem_i_store_loc_out;
  logic [NBITS:0]  mem_j_store_loc_out;
  logic [MBITS:0]  mem_m_store_size_out;
  logic [NBITS:0]  mem_n_store_size_out;

  modport master (
    output mem_store_valid_out,
    output mem_store_element_out,
    output mem_i_store_loc_out,
    output mem_j_store_loc_out,
    output mem_m_store_size_out,
    output mem_n_store_size_out,
    input  mem_store_ready_in
  );

  modport slave (
    input  mem_store_valid_out,
    input  mem_store_element_out,
    input  mem_i_store_loc_out,
    input  mem_j_store_loc_out,
    input  mem_m_store_size_out,
    input  mem_n_store_size_out,
    output mem_store_ready_in
  );
endinterface

// File: rtl/mpu_store_buf.sv
// rtl/mpu_store_buf.sv - two-entry FIFO of {element, i, j} between register-file reads and memory
module mpu_store_buf
  import mpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  store_entry_t push_data,
  input  logic         pop,
  output store_entry_t head,
  output logic [1:0]   count,
  output logic         empty
);

  store_entry_t mem [STORE_BUF_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         full;
  logic         push_ok;
  logic         pop_ok;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int k = 0; k < STORE_BUF_DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

endmodule

// File: rtl/mpu_store.sv
// rtl/mpu_store.sv - MPU store path: reads a matrix row-major from the register file and streams it out
module mpu_store
  import global_defs::*;
  import mpu_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     store_en_in,
  input  logic [MATRIX_REG_BITS:0] mem_store_addr_in,
  mpu_store_if.master              mem,
  output logic                     mem_store_busy_out,
  output logic                     mem_store_done_out,
  output logic                     mem_store_error_out,
  output logic                     reg_store_en_out,
  output logic [MATRIX_REG_BITS:0] reg_store_addr_out,
  output logic [MBITS:0]           reg_i_store_loc_out,
  output logic [NBITS:0]           reg_j_store_loc_out,
  input  logic [FPBITS:0]          reg_store_element_in,
  input  logic [MBITS:0]           reg_m_store_size_in,
  input  logic [NBITS:0]           reg_n_store_size_in
);

  localparam logic [1:0]     ST_IDLE  = STORE_IDLE;
  localparam logic [1:0]     ST_READ  = STORE_READ;
  localparam logic [1:0]     ST_DRAIN = STORE_DRAIN;
  localparam logic [1:0]     ST_DONE  = STORE_DONE;
  localparam logic [MBITS:0] M_ONE    = 1;
  localparam logic [NBITS:0] N_ONE    = 1;

  logic [1:0]               state;
  logic [MATRIX_REG_BITS:0] addr_q;
  logic [MBITS:0]           m_q;
  logic [NBITS:0]           n_q;
  logic [MBITS:0]           row_ptr;
  logic [NBITS:0]           col_ptr;
  logic                     inflight;
  logic [MBITS:0]           rd_i_q;
  logic [NBITS:0]           rd_j_q;
  logic                     error_q;

  store_entry_t             push_data;
  store_entry_t             head;
  logic [1:0]               buf_count;
  logic                     buf_empty;

  logic                     pop;
  logic [2:0]               fill;
  logic                     issue;
  logic                     col_last;
  logic                     last_issue;
  logic                     req_err;

  // Occupancy the buffer will have once this cycle's pop and pending read data settle.
  assign pop        = !buf_empty && mem.mem_store_ready_in;
  assign fill       = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue      = (state == ST_READ) && (fill < 3'd2);
  assign col_last   = (col_ptr == n_q - N_ONE);
  assign last_issue = issue && col_last && (row_ptr == m_q - M_ONE);
  assign req_err    = size_error(reg_m_store_size_in, reg_n_store_size_in);

  assign reg_store_addr_out  = (state == ST_IDLE) ? mem_store_addr_in : addr_q;
  assign reg_store_en_out    = issue;
  assign reg_i_store_loc_out = row_ptr;
  assign reg_j_store_loc_out = col_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      addr_q   <= '0;
      m_q      <= '0;
      n_q      <= '0;
      row_ptr  <= '0;
      col_ptr  <= '0;
      inflight <= 1'b0;
      rd_i_q   <= '0;
      rd_j_q   <= '0;
      error_q  <= 1'b0;
    end else begin
      error_q  <= 1'b0;
      inflight <= issue;
      if (issue) begin
        rd_i_q <= row_ptr;
        rd_j_q <= col_ptr;
      end
      case (state)
        ST_IDLE: begin
          if (store_en_in) begin
            if (req_err) begin
              error_q <= 1'b1;
            end else begin
              addr_q  <= mem_store_addr_in;
              m_q     <= reg_m_store_size_in;
              n_q     <= reg_n_store_size_in;
              row_ptr <= '0;
              col_ptr <= '0;
              state   <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (issue) begin
            if (col_last) begin
              col_ptr <= '0;
              row_ptr <= row_ptr + M_ONE;
            end else begin
              col_ptr <= col_ptr + N_ONE;
            end
            if (last_issue) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (fill == 3'd0) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign push_data.element = reg_store_element_in;
  assign push_data.i       = rd_i_q;
  assign push_data.j       = rd_j_q;

  mpu_store_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (buf_count),
    .empty     (buf_empty)
  );

  assign mem.mem_store_valid_out   = !buf_empty;
  assign mem.mem_store_element_out = head.element;
  assign mem.mem_i_store_loc_out   = head.i;
  assign mem.mem_j_store_loc_out   = head.j;
  assign mem.mem_m_store_size_out  = mem_store_busy_out ? m_q : '0;
  assign mem.mem_n_store_size_out  = mem_store_busy_out ? n_q : '0;

  assign mem_store_busy_out  = (state != ST_IDLE);
  assign mem_store_done_out  = (state == ST_DONE);
  assign mem_store_error_out = error_q;

endmodule

// File: tb/tb_mpu_store.sv
// tb/tb_mpu_store.sv - randomized scoreboard bench for mpu_store
module tb_mpu_store;
  import global_defs::*;
  import mpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        store_en;
  logic [2:0]  addr_in;
  logic        busy, done, error;
  logic        reg_en;
  logic [2:0]  reg_addr, reg_i, reg_j;
  logic [31:0] reg_elem;
  logic [2:0]  reg_m, reg_n;

  mpu_store_if mem_if ();

  mpu_store dut (
    .clk                  (clk),
    .rst                  (rst),
    .store_en_in          (store_en),
    .mem_store_addr_in    (addr_in),
    .mem                  (mem_if),
    .mem_store_busy_out   (busy),
    .mem_store_done_out   (done),
    .mem_store_error_out  (error),
    .reg_store_en_out     (reg_en),
    .reg_store_addr_out   (reg_addr),
    .reg_i_store_loc_out  (reg_i),
    .reg_j_store_loc_out  (reg_j),
    .reg_store_element_in (reg_elem),
    .reg_m_store_size_in  (reg_m),
    .reg_n_store_size_in  (reg_n)
  );

  always #5 clk = ~clk;

  logic [31:0] mats [8][4][4];
  logic [2:0]  size_m [8];
  logic [2:0]  size_n [8];

  assign reg_m = size_m[reg_addr];
  assign reg_n = size_n[reg_addr];

  always @(posedge clk) begin
    if (reg_en && reg_i < 3'd4 && reg_j < 3'd4)
      reg_elem <= mats[reg_addr][reg_i[1:0]][reg_j[1:0]];
    else
      reg_elem <= $urandom;
  end

  typedef struct {
    logic [31:0] e;
    logic [2:0]  i, j, m, n;
  } exp_t;
  exp_t q[$];

  int passes = 0;
  int checks = 0;
  int cyc = 0;
  int reads, first_read, last_read, first_valid, valid_cnt, stall_cnt;
  int done_cnt, done_cyc, err_cnt, err_cyc, last_busy, busy_cnt, hs_cyc, outstanding;
  int rmode = 0;
  int hold_target = 0;
  int acc;
  logic [2:0]  cur_addr = 3'd0;
  logic [31:0] hs_e[$];
  logic [2:0]  hs_i[$], hs_j[$];
  bit          prev_stall = 1'b0;
  logic [31:0] prev_e;
  logic [2:0]  prev_i, prev_j;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    mem_if.mem_store_ready_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: mem_if.mem_store_ready_in = 1'b1;
        1: mem_if.mem_store_ready_in = (cyc % 3 == 0);
        2: mem_if.mem_store_ready_in = 1'($urandom_range(0, 1));
        3: mem_if.mem_store_ready_in = (valid_cnt >= hold_target);
        default: mem_if.mem_store_ready_in = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (reg_en) begin
        reads++;
        if (first_read < 0) first_read = cyc;
        last_read = cyc;
        outstanding++;
        check(reg_addr == cur_addr, "read_addr", reg_addr, cur_addr);
      end
      if (mem_if.mem_store_valid_out) begin
        valid_cnt++;
        if (first_valid < 0) first_valid = cyc;
        if (prev_stall) begin
          check(mem_if.mem_store_element_out == prev_e, "stall_elem", mem_if.mem_store_element_out, prev_e);
          check(mem_if.mem_i_store_loc_out == prev_i && mem_if.mem_j_store_loc_out == prev_j,
                "stall_loc", {mem_if.mem_i_store_loc_out, mem_if.mem_j_store_loc_out}, {prev_i, prev_j});
        end
        if (mem_if.mem_store_ready_in) begin
          if (q.size() == 0) begin
            check(1'b0, "unexpected_element", mem_if.mem_store_element_out, 0);
          end else begin
            exp_t x;
            x = q.pop_front();
            check(mem_if.mem_store_element_out == x.e, "element", mem_if.mem_store_element_out, x.e);
            check(mem_if.mem_i_store_loc_out == x.i, "loc_i", mem_if.mem_i_store_loc_out, x.i);
            check(mem_if.mem_j_store_loc_out == x.j, "loc_j", mem_if.mem_j_store_loc_out, x.j);
            check(mem_if.mem_m_store_size_out == x.m, "size_m", mem_if.mem_m_store_size_out, x.m);
            check(mem_if.mem_n_store_size_out == x.n, "size_n", mem_if.mem_n_store_size_out, x.n);
          end
          hs_e.push_back(mem_if.mem_store_element_out);
          hs_i.push_back(mem_if.mem_i_store_loc_out);
          hs_j.push_back(mem_if.mem_j_store_loc_out);
          hs_cyc = cyc;
          outstanding--;
        end else begin
          stall_cnt++;
        end
        prev_stall = !mem_if.mem_store_ready_in;
        prev_e     = mem_if.mem_store_element_out;
        prev_i     = mem_if.mem_i_store_loc_out;
        prev_j     = mem_if.mem_j_store_loc_out;
      end else begin
        if (prev_stall) check(1'b0, "valid_dropped", 0, 1);
        prev_stall = 1'b0;
      end
      if (busy) begin
        busy_cnt++;
        last_busy = cyc;
        check(outstanding <= 2, "outstanding", outstanding, 2);
      end else begin
        check(!mem_if.mem_store_valid_out && mem_if.mem_m_store_size_out == 0 && mem_if.mem_n_store_size_out == 0,
              "idle_outputs", {mem_if.mem_store_valid_out, mem_if.mem_m_store_size_out, mem_if.mem_n_store_size_out}, 0);
      end
      if (done || error) check(!(done && error), "done_and_error", {done, error}, 0);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check(q.size() == 0, "done_all_delivered", q.size(), 0);
      end
      if (error) begin
        err_cnt++;
        err_cyc = cyc;
      end
    end
  end

  task automatic reset_stats();
    reads = 0; first_read = -1; last_read = -1; first_valid = -1; valid_cnt = 0; stall_cnt = 0;
    done_cnt = 0; done_cyc = -1; err_cnt = 0; err_cyc = -1; last_busy = -1; busy_cnt = 0; hs_cyc = -1;
    hs_e.delete(); hs_i.delete(); hs_j.delete();
  endtask

  function automatic bit legal(input logic [2:0] a);
    return size_m[a] >= 1 && size_m[a] <= 4 && size_n[a] >= 1 && size_n[a] <= 4;
  endfunction

  task automatic load_expected(input logic [2:0] a);
    exp_t x;
    if (legal(a)) begin
      for (int i = 0; i < int'(size_m[a]); i++) begin
        for (int j = 0; j < int'(size_n[a]); j++) begin
          x.e = mats[a][i][j]; x.i = 3'(i); x.j = 3'(j); x.m = size_m[a]; x.n = size_n[a];
          q.push_back(x);
        end
      end
    end
  endtask

  task automatic request(input logic [2:0] a);
    @(posedge clk); #1;
    store_en = 1'b1; addr_in = a; acc = cyc; cur_addr = a;
    load_expected(a);
    @(posedge clk); #1;
    store_en = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (done_cnt > 0 || err_cnt > 0) break;
    end
    if (k == budget) check(1'b0, "timeout", k, budget);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic fill_mat(input logic [2:0] a);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        mats[a][i][j] = $urandom;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; store_en = 1'b0; addr_in = 3'd0;
    for (int a = 0; a < 8; a++) begin
      size_m[a] = 3'd2; size_n[a] = 3'd2; fill_mat(3'(a));
    end
    reset_stats();
    repeat (3) @(posedge clk);
    #1;
    check(!busy && !done && !error && !reg_en && !mem_if.mem_store_valid_out, "reset_state",
          {busy, done, error, reg_en, mem_if.mem_store_valid_out}, 0);
    rst = 1'b0;

    // 2x2, ready high: exact latency and row-major order
    mats[1][0][0] = 32'h3F800000; mats[1][0][1] = 32'h40000000;
    mats[1][1][0] = 32'h40400000; mats[1][1][1] = 32'h40800000;
    rmode = 0; reset_stats(); request(3'd1); wait_end(50);
    check(reads == 4, "t1_reads", reads, 4);
    check(first_read == acc + 1, "t1_first_read", first_read, acc + 1);
    check(last_read == acc + 4, "t1_last_read", last_read, acc + 4);
    check(first_valid == acc + 3, "t1_first_valid", first_valid, acc + 3);
    check(done_cyc == acc + 7, "t1_done_cycle", done_cyc, acc + 7);
    check(last_busy == acc + 7, "t1_last_busy", last_busy, acc + 7);
    check(hs_e.size() == 4, "t1_count", hs_e.size(), 4);
    if (hs_e.size() == 4) begin
      check(hs_e[0] == 32'h3F800000 && hs_e[3] == 32'h40800000, "t1_elem_literal", hs_e[3], 32'h40800000);
      check({hs_i[0], hs_j[0], hs_i[1], hs_j[1], hs_i[2], hs_j[2], hs_i[3], hs_j[3]} == 24'o00011011,
            "t1_order", {hs_i[1], hs_j[1], hs_i[2], hs_j[2]}, 12'o0110);
    end

    // 3x4 with ready pattern 1,0,0
    size_m[2] = 3'd3; size_n[2] = 3'd4; fill_mat(3'd2);
    rmode = 1; reset_stats(); request(3'd2); wait_end(200);
    check(hs_e.size() == 12, "t2_count", hs_e.size(), 12);
    check(done_cnt == 1, "t2_done", done_cnt, 1);
    check(q.size() == 0, "t2_queue_empty", q.size(), 0);

    // rejected sizes
    for (int t = 0; t < 4; t++) begin
      logic [5:0] tab;
      tab = (t == 0) ? 6'o03 : (t == 1) ? 6'o52 : (t == 2) ? 6'o25 : 6'o30;
      size_m[3] = tab[5:3]; size_n[3] = tab[2:0];
      rmode = 0; reset_stats(); request(3'd3); wait_end(10);
      check(err_cnt == 1, "t3_error_pulse", err_cnt, 1);
      check(err_cyc == acc + 1, "t3_error_cycle", err_cyc, acc + 1);
      check(reads == 0, "t3_no_reads", reads, 0);
      check(busy_cnt == 0 && done_cnt == 0, "t3_not_busy", busy_cnt, 0);
    end

    // store_en held, address changed mid-transfer
    size_m[4] = 3'd3; size_n[4] = 3'd3; fill_mat(3'd4);
    size_m[5] = 3'd2; size_n[5] = 3'd2; fill_mat(3'd5);
    rmode = 2; reset_stats();
    @(posedge clk); #1;
    store_en = 1'b1; addr_in = 3'd4; acc = cyc; cur_addr = 3'd4; load_expected(3'd4);
    repeat (3) @(posedge clk);
    #1 addr_in = 3'd5;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (done_cnt > 0) break;
    end
    store_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check(done_cnt == 1, "t4_single_done", done_cnt, 1);
    check(hs_e.size() == 9, "t4_count", hs_e.size(), 9);

    // reset in STORE_READ with one element buffered
    size_m[0] = 3'd3; size_n[0] = 3'd4; fill_mat(3'd0);
    rmode = 4; reset_stats(); request(3'd0);
    repeat (2) @(posedge clk);
    #1;
    check(mem_if.mem_store_valid_out && busy, "t5_pre_reset", {mem_if.mem_store_valid_out, busy}, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; q.delete();
    @(negedge clk);
    check({busy, done, error, reg_en, reg_addr, reg_i, reg_j, mem_if.mem_store_valid_out} == 0,
          "t5_ctrl_zero", {busy, done, error, reg_en, reg_addr, reg_i, reg_j}, 0);
    check({mem_if.mem_store_element_out, mem_if.mem_i_store_loc_out, mem_if.mem_j_store_loc_out,
           mem_if.mem_m_store_size_out, mem_if.mem_n_store_size_out} == 0, "t5_data_zero",
          mem_if.mem_store_element_out, 0);
    check(done_cnt == 0, "t5_no_done", done_cnt, 0);
    rmode = 0; reset_stats(); request(3'd0); wait_end(100);
    check(hs_e.size() == 12, "t5_restart_count", hs_e.size(), 12);
    if (hs_e.size() > 0) check(hs_i[0] == 0 && hs_j[0] == 0, "t5_restart_origin", {hs_i[0], hs_j[0]}, 0);

    // 1x1 held off for five cycles
    size_m[6] = 3'd1; size_n[6] = 3'd1; fill_mat(3'd6);
    hold_target = 5; rmode = 3; reset_stats(); request(3'd6); wait_end(40);
    check(first_valid == acc + 3, "t6_first_valid", first_valid, acc + 3);
    check(stall_cnt == 5, "t6_hold", stall_cnt, 5);
    check(done_cyc == hs_cyc + 1, "t6_done_after_hs", done_cyc, hs_cyc + 1);
    check(hs_e.size() == 1, "t6_count", hs_e.size(), 1);

    // randomized transfers
    for (int it = 0; it < 25; it++) begin
      logic [2:0] a;
      a = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 4) == 0) begin
        size_m[a] = 3'($urandom_range(0, 5)); size_n[a] = 3'($urandom_range(0, 5));
      end else begin
        size_m[a] = 3'($urandom_range(1, 4)); size_n[a] = 3'($urandom_range(1, 4));
      end
      fill_mat(a);
      rmode = $urandom_range(0, 2); reset_stats(); request(a); wait_end(300);
      if (legal(a)) begin
        check(done_cnt == 1, "rnd_done", done_cnt, 1);
        check(hs_e.size() == int'(size_m[a]) * int'(size_n[a]), "rnd_count", hs_e.size(),
              int'(size_m[a]) * int'(size_n[a]));
      end else begin
        check(err_cnt == 1 && reads == 0, "rnd_reject", err_cnt, 1);
      end
      check(q.size() == 0, "rnd_queue_empty", q.size(), 0);
      q.delete();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
